// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, pipeline-register layouts and field helpers.
// Pure definitions: no state, no latency, no flow control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        regwrite;
    logic        memread;
  } idex_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic [31:0] imm_extend(input logic [5:0] op, input logic [15:0] imm16);
    logic [31:0] result;
    if (op == OP_ANDI || op == OP_ORI) begin
      result = {16'h0000, imm16};
    end else begin
      result = {{16{imm16[15]}}, imm16};
    end
    return result;
  endfunction

  function automatic logic writes_reg(input logic [5:0] op, input logic [5:0] funct);
    logic result;
    case (op)
      OP_RTYPE: result = (funct != FUNCT_JR);
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect (LOADUSE_STALL_EN): combinational, zero latency, no flow control of its own.
// Without the macro the stall is tied low and the compiler is trusted to insert nops.
module hazard_unit
  import mips_pkg::*;
(
  input  logic       ifid_valid,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       id_valid,
  input  logic       id_memread,
  input  logic [4:0] id_dest,
  output logic       stall
);

`ifdef LOADUSE_STALL_EN
  always_comb begin
    stall = ifid_valid && id_valid && id_memread && (id_dest != REG_ZERO) &&
            ((id_dest == ifid_rs) || (id_dest == ifid_rt));
  end
`else
  logic unused_hazard;
  assign unused_hazard = ^{ifid_valid, ifid_rs, ifid_rt, id_valid, id_memread, id_dest};
  assign stall = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// MIPS decode: IF/ID + ID/EX registers, 2 edges accept-to-id_valid; load-use stall with LOADUSE_STALL_EN.
// Backpressure: ex_ready low holds both registers and drops if_ready; flush clears both.
module decode_stage
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  output logic [4:0]  Read1,
  output logic [4:0]  Read2,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic        id_regwrite,
  output logic        id_memread
);

  ifid_t ifid_q;
  idex_t idex_q;
  idex_t idex_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        stall;
  logic        advance;

  assign op    = ifid_q.instr[31:26];
  assign rs    = ifid_q.instr[25:21];
  assign rt    = ifid_q.instr[20:16];
  assign rd    = ifid_q.instr[15:11];
  assign imm16 = ifid_q.instr[15:0];
  assign funct = ifid_q.instr[5:0];

  assign Read1 = rs;
  assign Read2 = rt;

  hazard_unit u_hazard (
    .ifid_valid (ifid_q.valid),
    .ifid_rs    (rs),
    .ifid_rt    (rt),
    .id_valid   (idex_q.valid),
    .id_memread (idex_q.memread),
    .id_dest    (idex_q.dest),
    .stall      (stall)
  );

  assign advance  = !stall && (!idex_q.valid || ex_ready);
  assign if_ready = !ifid_q.valid || advance;

  // Register $0 is hardwired: ignore whatever the register file returns for it.
  always_comb begin
    idex_d          = '0;
    idex_d.valid    = 1'b1;
    idex_d.instr    = ifid_q.instr;
    idex_d.rs_data  = (rs == REG_ZERO) ? 32'h0 : Data1;
    idex_d.rt_data  = (rt == REG_ZERO) ? 32'h0 : Data2;
    idex_d.imm      = imm_extend(op, imm16);
    idex_d.dest     = (op == OP_RTYPE) ? rd : rt;
    idex_d.regwrite = writes_reg(op, funct);
    idex_d.memread  = (op == OP_LW);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ifid_q <= '0;
    end else if (flush) begin
      ifid_q.valid <= 1'b0;
    end else if (if_ready) begin
      ifid_q.valid <= if_valid;
      if (if_valid) begin
        ifid_q.instr <= if_instr;
      end
    end
  end

  // A bubble is an all-zero record, so its control bits are inert.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_q <= '0;
    end else if (flush) begin
      idex_q <= '0;
    end else if (advance) begin
      idex_q <= ifid_q.valid ? idex_d : '0;
    end else if (stall && ex_ready) begin
      idex_q <= '0;
    end
  end

  assign id_valid    = idex_q.valid;
  assign id_instr    = idex_q.instr;
  assign id_rs_data  = idex_q.rs_data;
  assign id_rt_data  = idex_q.rt_data;
  assign id_imm      = idex_q.imm;
  assign id_dest     = idex_q.dest;
  assign id_regwrite = idex_q.regwrite;
  assign id_memread  = idex_q.memread;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed corner sequences, then a randomly throttled
// table-driven stream checked through an in-order scoreboard.
module tb_decode_stage;

`ifdef LOADUSE_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  localparam logic [31:0] I_ADDI8 = 32'h20080005;
  localparam logic [31:0] I_ORI   = 32'h340CFFFF;
  localparam logic [31:0] I_ANDI  = 32'h30838000;
  localparam logic [31:0] I_SLTI  = 32'h28A4FFFD;
  localparam logic [31:0] I_LW    = 32'h8E090000;
  localparam logic [31:0] I_ADD   = 32'h01285020;
  localparam int          NVEC    = 13;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic        id_regwrite;
  logic        id_memread;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NVEC];
  vec_t sb[$];

  decode_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .Read1       (Read1),
    .Read2       (Read2),
    .Data1       (Data1),
    .Data2       (Data2),
    .ex_ready    (ex_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .id_imm      (id_imm),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file returns junk for $0 so the hardwired-zero path is exercised.
  function automatic logic [31:0] rf_model(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0000DEAD : (32'hC0DE0000 | {27'd0, idx});
  endfunction

  function automatic logic [31:0] exp_operand(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : rf_model(idx);
  endfunction

  always_comb begin
    Data1 = rf_model(Read1);
    Data2 = rf_model(Read2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_two(input logic [31:0] first, input logic [31:0] second);
    ex_ready = 1'b1;
    if_valid = 1'b1;
    if_instr = first;
    tick();
    if_instr = second;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] got_instr;
    int          got_edge;
    int          idx;
    int          cyc;
    vec_t        e;

    vecs[0]  = '{32'h20080005, 5'd8,  32'h00000005, 1'b1, 1'b0}; // addi $8,$0,5
    vecs[1]  = '{32'h340CFFFF, 5'd12, 32'h0000FFFF, 1'b1, 1'b0}; // ori $12,$0,0xFFFF
    vecs[2]  = '{32'h200CFFFF, 5'd12, 32'hFFFFFFFF, 1'b1, 1'b0}; // addi $12,$0,-1
    vecs[3]  = '{32'h30838000, 5'd3,  32'h00008000, 1'b1, 1'b0}; // andi $3,$4,0x8000
    vecs[4]  = '{32'h8E090000, 5'd9,  32'h00000000, 1'b1, 1'b1}; // lw $9,0($16)
    vecs[5]  = '{32'h01285020, 5'd10, 32'h00005020, 1'b1, 1'b0}; // add $10,$9,$8
    vecs[6]  = '{32'h03E00008, 5'd0,  32'h00000008, 1'b0, 1'b0}; // jr $31
    vecs[7]  = '{32'hACC50004, 5'd5,  32'h00000004, 1'b0, 1'b0}; // sw $5,4($6)
    vecs[8]  = '{32'h3C078001, 5'd7,  32'hFFFF8001, 1'b1, 1'b0}; // lui $7,0x8001
    vecs[9]  = '{32'h1022FFFE, 5'd2,  32'hFFFFFFFE, 1'b0, 1'b0}; // beq $1,$2,-2
    vecs[10] = '{32'h28A4FFFD, 5'd4,  32'hFFFFFFFD, 1'b1, 1'b0}; // slti $4,$5,-3
    vecs[11] = '{32'h8C200008, 5'd0,  32'h00000008, 1'b1, 1'b1}; // lw $0,8($1)
    vecs[12] = '{32'h00001020, 5'd2,  32'h00001020, 1'b1, 1'b0}; // add $2,$0,$0

    flush = 1'b0; if_valid = 1'b0; if_instr = 32'h0; ex_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_ctrl", {30'd0, id_regwrite, id_memread}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Two-edge latency for a single addi.
    if_valid = 1'b1; if_instr = I_ADDI8;
    tick();
    if_valid = 1'b0;
    chk("lat_edge1_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("lat_edge2_valid", {31'd0, id_valid}, 32'd1);
    chk("lat_dest", {27'd0, id_dest}, 32'd8);
    chk("lat_imm", id_imm, 32'd5);
    chk("lat_regwrite", {31'd0, id_regwrite}, 32'd1);
    chk("lat_rs_zero", id_rs_data, 32'd0);
    tick();
    chk("lat_drain", {31'd0, id_valid}, 32'd0);

    // Load-use pair: one bubble only when the stall logic is built in.
    fill_two(I_LW, I_ADD);
    if_valid = 1'b0;
    #1;
    chk("lu_if_ready", {31'd0, if_ready}, STALL_ON ? 32'd0 : 32'd1);
    chk("lu_lw_out", id_instr, I_LW);
    got_instr = 32'h0; got_edge = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) chk("lu_slot1_valid", {31'd0, id_valid}, STALL_ON ? 32'd0 : 32'd1);
      if (id_valid && got_edge == 0) begin
        got_edge = k;
        got_instr = id_instr;
      end
    end
    chk("lu_add_edge", got_edge, STALL_ON ? 32'd2 : 32'd1);
    chk("lu_add_instr", got_instr, I_ADD);

    // Backpressure: both registers full, ex_ready low for 3 cycles.
    fill_two(I_ADDI8, I_ORI);
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ANDI;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, id_valid}, 32'd1);
      chk("bp_hold_instr", id_instr, I_ADDI8);
      chk("bp_hold_imm", id_imm, 32'd5);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    chk("bp_resume_b", id_instr, I_ORI);
    chk("bp_resume_b_imm", id_imm, 32'h0000FFFF);
    tick();
    chk("bp_resume_c", id_instr, I_ANDI);
    chk("bp_resume_c_imm", id_imm, 32'h00008000);
    tick();
    chk("bp_drain", {31'd0, id_valid}, 32'd0);

    // Flush beats a same-cycle transfer; nothing in flight reappears.
    fill_two(I_ADDI8, I_ORI);
    flush = 1'b1; if_valid = 1'b1; if_instr = I_SLTI;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("fl_valid_next", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_stays_empty", {31'd0, id_valid}, 32'd0);
    end

    // Asynchronous reset while holding (and stalled, if enabled).
    fill_two(I_LW, I_ADD);
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ANDI;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("arst_outputs", id_instr | id_imm | id_rs_data | id_rt_data, 32'd0);
    chk("arst_ctrl", {25'd0, id_dest, id_regwrite, id_memread}, 32'd0);
    if_valid = 1'b0; ex_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("arst_no_survivor", {31'd0, id_valid}, 32'd0);
    end

    // Throttled stream through the scoreboard.
    do_reset();
    idx = 0; cyc = 0;
    while ((idx < NVEC || sb.size() != 0) && cyc < 3000) begin
      if_valid = (idx < NVEC) && ($urandom_range(0, 3) != 0);
      if_instr = if_valid ? vecs[idx].instr : 32'h0;
      ex_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (id_valid && ex_ready) begin
        if (sb.size() == 0) begin
          chk("stream_unexpected", id_instr, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("stream_instr", id_instr, e.instr);
          chk("stream_dest", {27'd0, id_dest}, {27'd0, e.dest});
          chk("stream_imm", id_imm, e.imm);
          chk("stream_ctrl", {30'd0, id_regwrite, id_memread}, {30'd0, e.regwrite, e.memread});
          chk("stream_rs", id_rs_data, exp_operand(e.instr[25:21]));
          chk("stream_rt", id_rt_data, exp_operand(e.instr[20:16]));
        end
      end
      if (if_valid && if_ready) begin
        sb.push_back(vecs[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    if_valid = 1'b0;
    chk("stream_issued", idx, NVEC);
    chk("stream_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
